// File: rtl/seg_scan_controller.sv
// Multiplexed scanner for a common-anode seven-segment display sharing one hex decoder.
// Shadowed CPU writes are committed only at a frame boundary so every frame shows one consistent value.
module seg_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [4*NUM_DIGITS-1:0] wr_value,
  input  logic [NUM_DIGITS-1:0]   wr_dots,
  input  logic                    lz_blank,
  output logic                    wr_pending,
  output logic                    wr_ack,
  output logic [3:0]              dig,
  output logic                    dot,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [IW-1:0]           digit_idx
);

  localparam int MAXC = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_val_q, act_val_d, sh_val_q, sh_val_d;
  logic [NUM_DIGITS-1:0]   act_dots_q, act_dots_d, sh_dots_q, sh_dots_d;
  logic                    pend_q, pend_d, ack_q, ack_d, dot_q, dot_d;
  logic [3:0]              dig_q, dig_d;
  logic [4*NUM_DIGITS-1:0] sel_val;
  logic [NUM_DIGITS-1:0]   sel_dots;
  logic [NUM_DIGITS-1:0]   zero_above;
  logic                    suppress;

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    idx_d      = idx_q;
    act_val_d  = act_val_q;
    act_dots_d = act_dots_q;
    sh_val_d   = sh_val_q;
    sh_dots_d  = sh_dots_q;
    pend_d     = pend_q;
    ack_d      = 1'b0;
    case (state_q)
      BLANK: begin
        if (timer_q == TW'(BLANK_CYCLES - 1)) begin
          state_d = SHOW;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      SHOW: begin
        if (timer_q == TW'(PRESCALE - 1)) begin
          state_d = BLANK;
          timer_d = '0;
          if (idx_q == IW'(NUM_DIGITS - 1)) begin
            idx_d = '0;
            if (pend_q) begin
              act_val_d  = sh_val_q;
              act_dots_d = sh_dots_q;
              pend_d     = 1'b0;
              ack_d      = 1'b1;
            end
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = BLANK;
    endcase
    // A write in the commit cycle lands after the commit has taken the old shadow.
    if (wr_en) begin
      sh_val_d  = wr_value;
      sh_dots_d = wr_dots;
      pend_d    = 1'b1;
    end
    sel_val  = act_val_d >> {idx_d, 2'b00};
    sel_dots = act_dots_d >> idx_d;
    dig_d    = sel_val[3:0];
    dot_d    = sel_dots[0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BLANK;
      timer_q    <= '0;
      idx_q      <= '0;
      act_val_q  <= '0;
      act_dots_q <= '0;
      sh_val_q   <= '0;
      sh_dots_q  <= '0;
      pend_q     <= 1'b0;
      ack_q      <= 1'b0;
      dig_q      <= 4'h0;
      dot_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      act_val_q  <= act_val_d;
      act_dots_q <= act_dots_d;
      sh_val_q   <= sh_val_d;
      sh_dots_q  <= sh_dots_d;
      pend_q     <= pend_d;
      ack_q      <= ack_d;
      dig_q      <= dig_d;
      dot_q      <= dot_d;
    end
  end

  // zero_above[i]: digit i and every higher digit have a zero nibble and no dot.
  always_comb begin
    logic z;
    z = 1'b1;
    zero_above = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z = z && (act_val_q[4*i +: 4] == 4'h0) && !act_dots_q[i];
      zero_above[i] = z;
    end
  end

  always_comb begin
    suppress = lz_blank && (idx_q != '0) && zero_above[idx_q];
    an_n     = '1;
    if (state_q == SHOW && !suppress) begin
      an_n = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q);
    end
  end

  assign wr_pending = pend_q;
  assign wr_ack     = ack_q;
  assign dig        = dig_q;
  assign dot        = dot_q;
  assign digit_idx  = idx_q;

endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
- Time-multiplexed scanner for an N-digit common-anode seven-segment display.
- Each digit has its own active-low anode line. All digits share one SevSegController hex decoder.
- The block sequences the shared decoder across digits and inserts an anti-ghosting blank interval between digits.
- The CPU side writes a new display value through a shadow register. The shadow is committed only at a frame boundary, so no frame ever shows a mix of old and new digits.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- PRESCALE, 50000, clk cycles each digit is lit per visit (>=1).
- BLANK_CYCLES, 16, clk cycles all anodes are off before each digit is lit (>=1).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- wr_en  in  1  one-cycle strobe; captures wr_value/wr_dots into the shadow register.
- wr_value  in  4*NUM_DIGITS  hex nibbles; nibble i is digit i (digit 0 = least significant).
- wr_dots  in  NUM_DIGITS  decimal-point request per digit; 1 = dot on.
- lz_blank  in  1  1 = suppress leading zero digits; digit 0 is never suppressed.
- wr_pending  out  1  shadow holds data that is not yet committed.
- wr_ack  out  1  one-cycle pulse on the commit cycle.
- dig  out  4  nibble to the decoder's dig input.
- dot  out  1  dot to the decoder's dot input (the decoder inverts it).
- an_n  out  NUM_DIGITS  anode enables, active low.
- digit_idx  out  clog2(NUM_DIGITS)  index of the digit currently being scanned.

Behaviour:
- Reset (rst_n=0 sampled at a clk edge):
  - state=BLANK, digit_idx=0, timer=0.
  - Active and shadow value/dots cleared to 0.
  - wr_pending=0, wr_ack=0, an_n all 1, dig=0, dot=0.
  - Reset asserted mid-frame abandons the frame immediately; the pending write is discarded.
- FSM, two states:
  - BLANK: an_n all 1. Lasts BLANK_CYCLES cycles, then goes to SHOW with timer cleared.
  - SHOW: an_n[digit_idx]=0 (unless suppressed), all other bits 1. Lasts PRESCALE cycles, then goes to BLANK.
  - On the SHOW->BLANK transition, digit_idx increments. It wraps from NUM_DIGITS-1 to 0.
- Frame period = NUM_DIGITS*(BLANK_CYCLES+PRESCALE) cycles.
- dig and dot are driven from registered state only:
  - dig = active nibble[digit_idx]; dot = active dot[digit_idx].
  - They change only on the cycle digit_idx changes, which is always the first BLANK cycle. They are therefore stable for the whole BLANK and SHOW of that digit.
- Leading-zero suppression: with lz_blank=1, digit i>0 is suppressed if its nibble and all higher nibbles are 0 and its dot bit is 0.
  - A suppressed digit keeps its anode at 1 through SHOW.
  - Its slot time is still consumed, so frame timing is unchanged.
  - lz_blank is sampled continuously; it is not shadowed.
- Write handling:
  - wr_en=1 loads the shadow from wr_value/wr_dots and sets wr_pending=1 on the next cycle.
  - A wr_en while already pending overwrites the shadow (last write wins); there is still one ack.
- Commit:
  - Occurs on the SHOW->BLANK edge where digit_idx wraps to 0, if wr_pending=1.
  - Active is loaded from the shadow and wr_pending goes to 0. wr_ack=1 for exactly that one cycle.
  - The new digit 0 uses the new value in that first BLANK cycle.
- wr_en on the commit cycle:
  - The commit takes the old shadow contents.
  - The new data is latched into the shadow, and wr_pending stays 1 until the next frame boundary.
- Active contents never change except at a commit. No partial update is ever visible.

Test Plan (NUM_DIGITS=4, PRESCALE=4, BLANK_CYCLES=2; cycle 0 = first cycle after rst_n rises):
- Scan timing:
  - Required: cycles 0-1 an_n=1111; cycles 2-5 an_n=1110; cycles 6-7 an_n=1111 with digit_idx=1; cycles 8-11 an_n=1101.
  - Pattern repeats every 24 cycles; dig changes only on cycles 0, 6, 12, 18.
- Commit: wr_en with wr_value=16'h12AF, wr_dots=4'b0100 at cycle 3.
  - Required: wr_pending=1 from cycle 4. wr_ack pulse at cycle 24 with wr_pending back to 0 there.
  - Cycle 24: dig=4'hF. Digit 1: dig=4'hA. Digit 2: dig=4'h2, dot=1. Digit 3: dig=4'h1.
  - Before cycle 24, dig=0 for all digits.
- Last write wins: writes of 16'h1111 at cycle 5 and 16'h2222 at cycle 10.
  - Required: a single wr_ack at cycle 24; all digits show 4'h2 afterwards.
- Write on the commit cycle: a pending write of 16'h0003, plus wr_en with 16'h0004 at cycle 24.
  - Required: frame 2 shows 3 and wr_pending stays 1.
  - Second wr_ack at cycle 48; frame 3 shows 4.
- Leading-zero suppression: active=16'h0050, dots=0, lz_blank=1.
  - Required: digits 2 and 3 keep an_n bit at 1 during SHOW.
  - Digit 1 (5) and digit 0 (0) light; frame period stays 24.
  - Setting dots=4'b1000 lights digit 3 and therefore digit 2 too.
- Reset mid-operation: rst_n low at cycle 14 while a write is pending.
  - Required: next cycle an_n=1111, digit_idx=0, wr_pending=0, dig=0.
  - The old value never reappears after reset.
